// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM states for the simulation memory.
package axi4_pkg;
   localparam int BEAT_BYTES = 8;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wstate_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rstate_e;
endpackage

// File: rtl/axi4_burst_addr.sv
// Next-beat address and burst legality for one AXI4 address channel.
module axi4_burst_addr
   import axi4_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        len,
   input  logic [2:0]        size,
   input  logic [1:0]        burst,
   output logic [ADDR_W-1:0] next_addr,
   output logic              legal
);
   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] mask;
   logic              wrap_len_ok;

   assign step = ONE << size;
   // wrap window is (len+1) beats of 2^size bytes, aligned to its size
   assign mask = (({{(ADDR_W-8){1'b0}}, len} + ONE) << size) - ONE;

   assign wrap_len_ok = (len == 8'd1) || (len == 8'd3) ||
                        (len == 8'd7) || (len == 8'd15);

   always_comb begin
      next_addr = addr;
      unique case (1'b1)
         burst == BURST_INCR:
            next_addr = addr + step;
         burst == BURST_WRAP:
            next_addr = (addr & ~mask) | ((addr + step) & mask);
         default:
            next_addr = addr;
      endcase
   end

   assign legal = (size <= 3'd3) && (burst != BURST_RSVD) &&
                  ((burst != BURST_WRAP) || wrap_len_ok);
endmodule

// File: rtl/axi4_sim_mem.sv
// AXI4 slave memory model: one outstanding burst per direction.
module axi4_sim_mem
   import axi4_pkg::*;
#(
   parameter int              ID_W      = 5,
   parameter int              ADDR_W    = 64,
   parameter int              MEM_LOG2  = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              S_AXI_awvalid,
   output logic              S_AXI_awready,
   input  logic [ID_W-1:0]   S_AXI_awid,
   input  logic [ADDR_W-1:0] S_AXI_awaddr,
   input  logic [7:0]        S_AXI_awlen,
   input  logic [2:0]        S_AXI_awsize,
   input  logic [1:0]        S_AXI_awburst,
   input  logic              S_AXI_awlock,
   input  logic [3:0]        S_AXI_awcache,
   input  logic [2:0]        S_AXI_awprot,
   input  logic [3:0]        S_AXI_awqos,
   input  logic              S_AXI_wvalid,
   output logic              S_AXI_wready,
   input  logic [63:0]       S_AXI_wdata,
   input  logic [7:0]        S_AXI_wstrb,
   input  logic              S_AXI_wlast,
   output logic              S_AXI_bvalid,
   input  logic              S_AXI_bready,
   output logic [ID_W-1:0]   S_AXI_bid,
   output logic [1:0]        S_AXI_bresp,
   input  logic              S_AXI_arvalid,
   output logic              S_AXI_arready,
   input  logic [ID_W-1:0]   S_AXI_arid,
   input  logic [ADDR_W-1:0] S_AXI_araddr,
   input  logic [7:0]        S_AXI_arlen,
   input  logic [2:0]        S_AXI_arsize,
   input  logic [1:0]        S_AXI_arburst,
   input  logic              S_AXI_arlock,
   input  logic [3:0]        S_AXI_arcache,
   input  logic [2:0]        S_AXI_arprot,
   input  logic [3:0]        S_AXI_arqos,
   output logic              S_AXI_rvalid,
   input  logic              S_AXI_rready,
   output logic [ID_W-1:0]   S_AXI_rid,
   output logic [63:0]       S_AXI_rdata,
   output logic [1:0]        S_AXI_rresp,
   output logic              S_AXI_rlast
);
   localparam int IDX_W = MEM_LOG2 - 3;

   logic [63:0] mem [0:(1<<IDX_W)-1];

   wstate_e           wstate, w_nxt;
   logic [ID_W-1:0]   w_id;
   logic [ADDR_W-1:0] waddr, w_next_addr, w_off;
   logic [7:0]        w_len, w_cnt;
   logic [2:0]        w_size;
   logic [1:0]        w_burst;
   logic              w_err, w_legal, w_ok;
   logic              aw_hs, w_hs, w_last_beat;

   rstate_e           rstate, r_nxt;
   logic [ADDR_W-1:0] raddr, r_next_addr, r_off;
   logic [ADDR_W-1:0] r_cur_addr, r_load_addr;
   logic [7:0]        r_len, r_cnt, r_cur_len;
   logic [2:0]        r_size, r_cur_size;
   logic [1:0]        r_burst, r_cur_burst;
   logic              r_idle, r_legal, r_ok;
   logic              ar_hs, r_hs;
   logic [63:0]       r_load_data;
   logic              unused_ok;

   assign aw_hs = S_AXI_awvalid && S_AXI_awready;
   assign w_hs  = S_AXI_wvalid && S_AXI_wready;
   assign ar_hs = S_AXI_arvalid && S_AXI_arready;
   assign r_hs  = S_AXI_rvalid && S_AXI_rready;

   axi4_burst_addr #(.ADDR_W(ADDR_W)) u_waddr (
      .addr      (waddr),
      .len       (w_len),
      .size      (w_size),
      .burst     (w_burst),
      .next_addr (w_next_addr),
      .legal     (w_legal)
   );

   assign w_off       = waddr - BASE_ADDR;
   assign w_ok        = w_legal && (w_off[ADDR_W-1:MEM_LOG2] == '0);
   assign w_last_beat = (w_cnt == w_len);

   always_ff @(posedge clock) begin
      if (reset) wstate <= W_IDLE;
      else       wstate <= w_nxt;
   end

   always_comb begin
      w_nxt         = wstate;
      S_AXI_awready = 1'b0;
      S_AXI_wready  = 1'b0;
      S_AXI_bvalid  = 1'b0;
      if (!reset) begin
         case (wstate)
            W_IDLE: begin
               S_AXI_awready = 1'b1;
               if (S_AXI_awvalid) w_nxt = W_DATA;
            end
            W_DATA: begin
               S_AXI_wready = 1'b1;
               if (S_AXI_wvalid && w_last_beat) w_nxt = W_RESP;
            end
            W_RESP: begin
               S_AXI_bvalid = 1'b1;
               if (S_AXI_bready) w_nxt = W_IDLE;
            end
            default: w_nxt = W_IDLE;
         endcase
      end
   end

   assign S_AXI_bid   = S_AXI_bvalid ? w_id : '0;
   assign S_AXI_bresp = !S_AXI_bvalid ? RESP_OKAY :
                        w_err ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge clock) begin
      if (reset) begin
         w_id    <= '0;
         waddr   <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_cnt   <= '0;
         w_err   <= 1'b0;
      end else if (aw_hs) begin
         w_id    <= S_AXI_awid;
         waddr   <= S_AXI_awaddr;
         w_len   <= S_AXI_awlen;
         w_size  <= S_AXI_awsize;
         w_burst <= S_AXI_awburst;
         w_cnt   <= '0;
         w_err   <= 1'b0;
      end else if (w_hs) begin
         waddr <= w_next_addr;
         w_cnt <= w_cnt + 8'd1;
         if (!w_ok || (S_AXI_wlast != w_last_beat)) w_err <= 1'b1;
      end
   end

   // faulting beats never touch the array
   always_ff @(posedge clock) begin
      if (w_hs && w_ok) begin
         for (int i = 0; i < BEAT_BYTES; i++) begin
            if (S_AXI_wstrb[i])
               mem[w_off[MEM_LOG2-1:3]][8*i +: 8] <= S_AXI_wdata[8*i +: 8];
         end
      end
   end

   assign r_idle      = (rstate == R_IDLE);
   assign r_cur_addr  = r_idle ? S_AXI_araddr  : raddr;
   assign r_cur_len   = r_idle ? S_AXI_arlen   : r_len;
   assign r_cur_size  = r_idle ? S_AXI_arsize  : r_size;
   assign r_cur_burst = r_idle ? S_AXI_arburst : r_burst;

   axi4_burst_addr #(.ADDR_W(ADDR_W)) u_raddr (
      .addr      (r_cur_addr),
      .len       (r_cur_len),
      .size      (r_cur_size),
      .burst     (r_cur_burst),
      .next_addr (r_next_addr),
      .legal     (r_legal)
   );

   assign r_load_addr = r_idle ? S_AXI_araddr : r_next_addr;
   assign r_off       = r_load_addr - BASE_ADDR;
   assign r_ok        = r_legal && (r_off[ADDR_W-1:MEM_LOG2] == '0);
   assign r_load_data = r_ok ? mem[r_off[MEM_LOG2-1:3]] : '0;

   always_ff @(posedge clock) begin
      if (reset) rstate <= R_IDLE;
      else       rstate <= r_nxt;
   end

   always_comb begin
      r_nxt         = rstate;
      S_AXI_arready = 1'b0;
      S_AXI_rvalid  = 1'b0;
      if (!reset) begin
         case (rstate)
            R_IDLE: begin
               S_AXI_arready = 1'b1;
               if (S_AXI_arvalid) r_nxt = R_DATA;
            end
            R_DATA: begin
               S_AXI_rvalid = 1'b1;
               if (S_AXI_rready && S_AXI_rlast) r_nxt = R_IDLE;
            end
            default: r_nxt = R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         raddr       <= '0;
         r_len       <= '0;
         r_size      <= '0;
         r_burst     <= '0;
         r_cnt       <= '0;
         S_AXI_rid   <= '0;
         S_AXI_rdata <= '0;
         S_AXI_rresp <= RESP_OKAY;
         S_AXI_rlast <= 1'b0;
      end else if (ar_hs) begin
         raddr       <= S_AXI_araddr;
         r_len       <= S_AXI_arlen;
         r_size      <= S_AXI_arsize;
         r_burst     <= S_AXI_arburst;
         r_cnt       <= '0;
         S_AXI_rid   <= S_AXI_arid;
         S_AXI_rdata <= r_load_data;
         S_AXI_rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
         S_AXI_rlast <= (S_AXI_arlen == 8'd0);
      end else if (r_hs) begin
         if (S_AXI_rlast) begin
            S_AXI_rlast <= 1'b0;
         end else begin
            raddr       <= r_next_addr;
            r_cnt       <= r_cnt + 8'd1;
            S_AXI_rdata <= r_load_data;
            S_AXI_rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
            S_AXI_rlast <= ((r_cnt + 8'd1) == r_len);
         end
      end
   end

   assign unused_ok = ^{S_AXI_awlock, S_AXI_awcache, S_AXI_awprot,
                        S_AXI_awqos, S_AXI_arlock, S_AXI_arcache,
                        S_AXI_arprot, S_AXI_arqos, w_off[2:0],
                        r_off[2:0]};
endmodule

// File: doc/axi4_sim_mem.md
Name: axi4_sim_mem

Overview:
- AXI4 slave (responder) memory model that terminates the 64-bit AXI4 master port driven by the Rocket Chip wrapper in Verilator and RTL simulation benches.
- Accepts INCR, FIXED and WRAP bursts on independent read and write channels.
- Stores data in an internal byte-addressable array and returns OKAY or SLVERR responses.
- One outstanding transaction per direction.

Parameters:
- ID_W, 5, AXI ID width.
- ADDR_W, 64, AXI address width.
- MEM_LOG2, 16, log2 of memory size in bytes (64 KiB default).
- BASE_ADDR, 64'h8000_0000, first byte address mapped by this slave.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- S_AXI_awvalid/awready  in/out  1  write address handshake
- S_AXI_awid  in  ID_W  write ID
- S_AXI_awaddr  in  ADDR_W  write start address
- S_AXI_awlen  in  8  beats minus 1
- S_AXI_awsize  in  3  log2 bytes per beat
- S_AXI_awburst  in  2  0 FIXED, 1 INCR, 2 WRAP
- S_AXI_awlock/awcache/awprot/awqos  in  1/4/3/4  ignored
- S_AXI_wvalid/wready  in/out  1  write data handshake
- S_AXI_wdata  in  64  write data
- S_AXI_wstrb  in  8  byte enables
- S_AXI_wlast  in  1  last write beat
- S_AXI_bvalid/bready  out/in  1  write response handshake
- S_AXI_bid  out  ID_W  echoed awid
- S_AXI_bresp  out  2  write response
- S_AXI_arvalid/arready  in/out  1  read address handshake
- S_AXI_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read request fields
- S_AXI_arlock/arcache/arprot/arqos  in  1/4/3/4  ignored
- S_AXI_rvalid/rready  out/in  1  read data handshake
- S_AXI_rid  out  ID_W  echoed arid
- S_AXI_rdata  out  64  read data
- S_AXI_rresp  out  2  read response
- S_AXI_rlast  out  1  last read beat

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values:
  - awready, arready, wready, bvalid and rvalid are 0 while reset is high.
  - bresp, rresp, bid, rid, rdata and rlast are 0.
  - Both FSMs go to IDLE.
  - Memory contents are retained.
- Reset mid-burst: the transaction is abandoned silently. No response is issued.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On an AW handshake, latch id, addr, len, size and burst; set beat_cnt=0 and err=0; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes where wstrb=1 at the current address's 8-byte word, then advances the address.
    - When beat_cnt==len, go to W_RESP.
    - If wlast does not equal (beat_cnt==len) on any beat, set err.
  - W_RESP: bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00. Hold until bready, then go to W_IDLE.
  - An AW handshake is never accepted while the write FSM is outside W_IDLE.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. The AR handshake latches the request and loads rdata from the array at the start word.
  - R_DATA: entered the next cycle with rvalid=1, so first-beat latency is 1 cycle.
  - Each R handshake advances the address and loads the next beat into rdata. rvalid stays 1, giving back-to-back beats.
  - rlast=1 when beat_cnt==len. The handshake on the last beat returns to R_IDLE.
  - rvalid, rdata, rresp, rid and rlast hold stable while rready=0.
- Address rules, shared by both FSMs:
  - FIXED: address unchanged.
  - INCR: addr + (1<<size).
  - WRAP: wrap within an aligned window of (len+1)<<size bytes. len must be 1, 3, 7 or 15, otherwise err.
  - Narrow transfers return the full 64-bit word. The master selects the lanes.
- Errors give SLVERR (2'b10) per beat for reads and in bresp for writes; the faulting write beat is suppressed. Error causes:
  - Address outside [BASE_ADDR, BASE_ADDR + 2^MEM_LOG2).
  - size > 3.
  - burst == 3.
  - Bursts that cross the region end error on the crossing beat onward.
- Read/write collision on the same word in the same cycle: the read loads the old data (read-before-write).
- Read and write channels operate fully concurrently.

Decomposition:
- axi4_pkg holds:
  - burst encodings (FIXED/INCR/WRAP);
  - resp codes (OKAY 2'b00, SLVERR 2'b10);
  - FSM state enums;
  - the beat-size constant 8.
- Sub-module axi4_burst_addr computes the combinational next address and the wrap/legal check from addr, len, size and burst. One instance serves each FSM.

Test Plan:
- Single write then read: AW addr 0x8000_0000, len 0, size 3, wdata 0x1122334455667788, wstrb 0xFF; then AR at the same address -> bresp 0, bid echoed; rdata 0x1122334455667788, rlast=1, rvalid exactly 1 cycle after AR handshake.
- INCR burst: len 3 at 0x8000_0100, data 0..3 with rready toggled every other cycle -> 4 beats in order, data stable while stalled, rlast only on beat 3.
- WRAP burst: len 3, size 3, start 0x8000_0010 -> beat addresses 0x10, 0x18, 0x00, 0x08 within the 32-byte window; a readback of 0x00 returns the third beat's data.
- Partial strobe: write 0xFFFF..FF with wstrb 0x0F over 0 -> readback 0x00000000FFFFFFFF.
- Error: AR at 0x7FFF_FFF8 -> rresp 2'b10; a write with wlast missing on the final beat -> bresp 2'b10, bid correct.
- Reset mid-burst: assert reset during write beat 2 of 4 -> bvalid never asserted, awready=1 one cycle after reset drops, a new transaction completes normally.
